// File: rtl/smem_query_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : smem_query_arbiter
// Brief    : Round-robin sharing of the 3-stage read-symbol RAM query port,
//            with a stall-aware tag pipeline that steers symbols back.
// Revision : 1.0 - initial release
// ============================================================================
module smem_query_arbiter #(
  parameter int                        NUM_REQ        = 4,
  parameter int                        READ_NUM_WIDTH = 6,
  parameter int                        POS_WIDTH      = 7,
  parameter int                        STATUS_WIDTH   = 6,
  parameter int                        LATENCY        = 3,
  parameter logic [STATUS_WIDTH-1:0]   BUBBLE         = 6'b110000
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                stall,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*READ_NUM_WIDTH-1:0]   req_read_num,
  input  logic [NUM_REQ*POS_WIDTH-1:0]        req_position,
  input  logic [NUM_REQ*STATUS_WIDTH-1:0]     req_status,
  output logic [NUM_REQ-1:0]                  req_grant,
  output logic [STATUS_WIDTH-1:0]             status_query,
  output logic [POS_WIDTH-1:0]                query_position,
  output logic [READ_NUM_WIDTH-1:0]           query_read_num,
  input  logic [7:0]                          new_read_query,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [7:0]                          rsp_data,
  output logic [POS_WIDTH-1:0]                rsp_position,
  output logic [READ_NUM_WIDTH-1:0]           rsp_read_num,
  output logic [1:0]                          in_flight,
  output logic                                idle
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1) + 1;
  localparam int LAST  = LATENCY - 1;

  logic [STATUS_WIDTH-1:0]   slice_status [NUM_REQ];
  logic [POS_WIDTH-1:0]      slice_pos    [NUM_REQ];
  logic [READ_NUM_WIDTH-1:0] slice_rd     [NUM_REQ];
  logic [NUM_REQ-1:0]        eligible;

  logic                      run;
  logic                      accept;
  logic [ID_W-1:0]           grant_id;
  logic [ID_W:0]             idx_sum;
  logic [ID_W:0]             rr_next;

  logic [ID_W-1:0]                            rr_ptr_q,    rr_ptr_d;
  logic [LATENCY-1:0]                         tag_valid_q, tag_valid_d;
  logic [LATENCY-1:0][ID_W-1:0]               tag_id_q,    tag_id_d;
  logic [LATENCY-1:0][POS_WIDTH-1:0]          tag_pos_q,   tag_pos_d;
  logic [LATENCY-1:0][READ_NUM_WIDTH-1:0]     tag_rd_q,    tag_rd_d;

  logic [CNT_W-1:0]          valid_cnt;

  // A requester parked on the idle status code never competes for the port.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign slice_status[gi] = req_status[gi*STATUS_WIDTH +: STATUS_WIDTH];
    assign slice_pos[gi]    = req_position[gi*POS_WIDTH +: POS_WIDTH];
    assign slice_rd[gi]     = req_read_num[gi*READ_NUM_WIDTH +: READ_NUM_WIDTH];
    assign eligible[gi]     = req_valid[gi] && (slice_status[gi] != BUBBLE);
  end

  // Reset also blocks grants so the RAM sees a bubble while reset is held.
  assign run = reset_n && !stall;

  always_comb begin
    req_grant = '0;
    grant_id  = '0;
    accept    = 1'b0;
    idx_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx_sum >= (ID_W+1)'(NUM_REQ)) begin
        idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
      end
      if (!accept && run && eligible[idx_sum[ID_W-1:0]]) begin
        accept                         = 1'b1;
        grant_id                       = idx_sum[ID_W-1:0];
        req_grant[idx_sum[ID_W-1:0]]   = 1'b1;
      end
    end
  end

  always_comb begin
    status_query   = BUBBLE;
    query_position = '0;
    query_read_num = '0;
    if (accept) begin
      status_query   = slice_status[grant_id];
      query_position = slice_pos[grant_id];
      query_read_num = slice_rd[grant_id];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    rr_next  = {1'b0, grant_id} + 1'b1;
    if (accept) begin
      rr_ptr_d = (rr_next == (ID_W+1)'(NUM_REQ)) ? '0 : rr_next[ID_W-1:0];
    end
  end

  // Tags shift only on edges where the RAM pipeline advances.
  always_comb begin
    tag_valid_d = tag_valid_q;
    tag_id_d    = tag_id_q;
    tag_pos_d   = tag_pos_q;
    tag_rd_d    = tag_rd_q;
    if (!stall) begin
      tag_valid_d[0] = accept;
      tag_id_d[0]    = grant_id;
      tag_pos_d[0]   = query_position;
      tag_rd_d[0]    = query_read_num;
      for (int k = 1; k < LATENCY; k++) begin
        tag_valid_d[k] = tag_valid_q[k-1];
        tag_id_d[k]    = tag_id_q[k-1];
        tag_pos_d[k]   = tag_pos_q[k-1];
        tag_rd_d[k]    = tag_rd_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      tag_valid_q <= '0;
      tag_id_q    <= '0;
      tag_pos_q   <= '0;
      tag_rd_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tag_valid_q <= tag_valid_d;
      tag_id_q    <= tag_id_d;
      tag_pos_q   <= tag_pos_d;
      tag_rd_q    <= tag_rd_d;
    end
  end

  always_comb begin
    rsp_valid    = '0;
    rsp_data     = '0;
    rsp_position = '0;
    rsp_read_num = '0;
    if (tag_valid_q[LAST]) begin
      rsp_data     = new_read_query;
      rsp_position = tag_pos_q[LAST];
      rsp_read_num = tag_rd_q[LAST];
      if (!stall) begin
        rsp_valid[tag_id_q[LAST]] = 1'b1;
      end
    end
  end

  always_comb begin
    valid_cnt = '0;
    for (int k = 0; k < LATENCY; k++) begin
      valid_cnt = valid_cnt + CNT_W'(tag_valid_q[k]);
    end
    in_flight = (valid_cnt > CNT_W'(3)) ? 2'd3 : valid_cnt[1:0];
  end

  assign idle = !(|tag_valid_q) && !(|req_valid);

endmodule
`default_nettype wire

// File: tb/tb_smem_query_arbiter.sv
`default_nettype none
// Directed bench for smem_query_arbiter with a small 3-stage stall-aware RAM model.
module tb_smem_query_arbiter;
  localparam int NR = 4;
  localparam int RW = 6;
  localparam int PW = 7;
  localparam int SW = 6;
  localparam int BUB = 48;

  logic              clk;
  logic              reset_n;
  logic              stall;
  logic [NR-1:0]     req_valid;
  logic [NR*RW-1:0]  req_read_num;
  logic [NR*PW-1:0]  req_position;
  logic [NR*SW-1:0]  req_status;
  logic [NR-1:0]     req_grant;
  logic [SW-1:0]     status_query;
  logic [PW-1:0]     query_position;
  logic [RW-1:0]     query_read_num;
  logic [7:0]        new_read_query;
  logic [NR-1:0]     rsp_valid;
  logic [7:0]        rsp_data;
  logic [PW-1:0]     rsp_position;
  logic [RW-1:0]     rsp_read_num;
  logic [1:0]        in_flight;
  logic              idle;

  int errors = 0;
  int checks = 0;

  smem_query_arbiter dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .req_valid(req_valid), .req_read_num(req_read_num),
    .req_position(req_position), .req_status(req_status),
    .req_grant(req_grant), .status_query(status_query),
    .query_position(query_position), .query_read_num(query_read_num),
    .new_read_query(new_read_query), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_position(rsp_position),
    .rsp_read_num(rsp_read_num), .in_flight(in_flight), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sym(input logic [RW-1:0] rd, input logic [PW-1:0] pos);
    return {rd[3:0], 4'h0} ^ {1'b0, pos} ^ 8'hA5;
  endfunction

  // RAM model: three stages that freeze on stall, symbol derived from the address.
  logic [RW-1:0] ram_rd  [3];
  logic [PW-1:0] ram_pos [3];
  always @(posedge clk) begin
    if (!stall) begin
      ram_rd[0]  <= query_read_num;
      ram_pos[0] <= query_position;
      ram_rd[1]  <= ram_rd[0];
      ram_pos[1] <= ram_pos[0];
      ram_rd[2]  <= ram_rd[1];
      ram_pos[2] <= ram_pos[1];
    end
  end
  always_comb new_read_query = sym(ram_rd[2], ram_pos[2]);

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input int rd, input int pos, input int st);
    req_valid[i]               = v;
    req_read_num[i*RW +: RW]   = RW'(rd);
    req_position[i*PW +: PW]   = PW'(pos);
    req_status[i*SW +: SW]     = SW'(st);
  endtask

  task automatic clear_reqs();
    req_valid    = '0;
    req_read_num = '0;
    req_position = '0;
    req_status   = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    stall   = 1'b0;
    clear_reqs();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, i + 1, i + 2, 1);
    repeat (2) @(posedge clk);
    settle();
    checks++; if (req_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b exp 0000", req_grant); end
    checks++; if (status_query !== SW'(BUB)) begin errors++; $display("FAIL reset_status_query: got %b exp %b", status_query, SW'(BUB)); end
    checks++; if (query_position !== 7'd0 || query_read_num !== 6'd0) begin errors++; $display("FAIL reset_query_fields: got pos %0d rd %0d exp 0 0", query_position, query_read_num); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0000", rsp_valid); end
    checks++; if (rsp_data !== 8'd0 || rsp_position !== 7'd0 || rsp_read_num !== 6'd0) begin errors++; $display("FAIL reset_rsp_fields: got %h %0d %0d exp 0 0 0", rsp_data, rsp_position, rsp_read_num); end
    checks++; if (in_flight !== 2'd0) begin errors++; $display("FAIL reset_in_flight: got %0d exp 0", in_flight); end
    clear_reqs();
    #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b exp 1", idle); end
    settle();
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 5, 37, 1);
    settle();
    checks++; if (req_grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b exp 0001", req_grant); end
    checks++; if (status_query !== 6'd1 || query_position !== 7'd37 || query_read_num !== 6'd5) begin errors++; $display("FAIL single_query: got st %0d pos %0d rd %0d exp 1 37 5", status_query, query_position, query_read_num); end
    next_cycle();
    clear_reqs();
    settle();
    checks++; if (rsp_valid !== 4'b0000 || in_flight !== 2'd1) begin errors++; $display("FAIL single_n1: got rsp %b inflight %0d exp 0000 1", rsp_valid, in_flight); end
    next_cycle();
    settle();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_n2: got rsp %b exp 0000", rsp_valid); end
    next_cycle();
    settle();
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b exp 0001", rsp_valid); end
    checks++; if (rsp_position !== 7'd37 || rsp_read_num !== 6'd5) begin errors++; $display("FAIL single_rsp_fields: got pos %0d rd %0d exp 37 5", rsp_position, rsp_read_num); end
    checks++; if (rsp_data !== sym(6'd5, 7'd37)) begin errors++; $display("FAIL single_rsp_data: got %h exp %h", rsp_data, sym(6'd5, 7'd37)); end
    next_cycle();
    settle();
    checks++; if (rsp_valid !== 4'b0000 || in_flight !== 2'd0 || idle !== 1'b1) begin errors++; $display("FAIL single_drain: got rsp %b inflight %0d idle %b exp 0000 0 1", rsp_valid, in_flight, idle); end
    next_cycle();
  endtask

  // Pointer sits at 1 after the single-request test.
  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [3:0] exp_r;
    int src;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 10 + i, 20 + i, i + 1);
      end else begin
        clear_reqs();
      end
      settle();
      exp_g = (c < 8) ? 4'(1 << ((1 + c) % 4)) : 4'b0000;
      checks++; if (req_grant !== exp_g) begin errors++; $display("FAIL rr_grant c%0d: got %b exp %b", c, req_grant, exp_g); end
      src   = (c + 2) % 4;
      exp_r = (c >= 3) ? 4'(1 << src) : 4'b0000;
      checks++; if (rsp_valid !== exp_r) begin errors++; $display("FAIL rr_rsp c%0d: got %b exp %b", c, rsp_valid, exp_r); end
      if (c >= 3) begin
        checks++;
        if (rsp_read_num !== RW'(10 + src) || rsp_position !== PW'(20 + src) || rsp_data !== sym(RW'(10 + src), PW'(20 + src))) begin
          errors++;
          $display("FAIL rr_rsp_fields c%0d: got rd %0d pos %0d data %h exp %0d %0d %h", c, rsp_read_num, rsp_position, rsp_data, 10 + src, 20 + src, sym(RW'(10 + src), PW'(20 + src)));
        end
      end
      next_cycle();
    end
  endtask

  // Pointer at 1: A=req1, B=req2 accepted, stall on cycles 3-4 with A in the last stage.
  task automatic test_stall();
    logic       t_stall [10] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    logic [3:0] t_req   [10] = '{4'b0110, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] t_gnt   [10] = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] t_rsp   [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
    int         t_rd    [10] = '{0, 0, 0, 0, 0, 31, 32, 0, 33, 0};
    logic [1:0] t_inf   [10] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    for (int c = 0; c < 10; c++) begin
      stall = t_stall[c];
      clear_reqs();
      for (int i = 0; i < NR; i++) if (t_req[c][i]) set_req(i, 1'b1, 30 + i, 40 + i, i + 1);
      settle();
      checks++; if (req_grant !== t_gnt[c]) begin errors++; $display("FAIL stall_grant c%0d: got %b exp %b", c, req_grant, t_gnt[c]); end
      checks++; if (rsp_valid !== t_rsp[c]) begin errors++; $display("FAIL stall_rsp c%0d: got %b exp %b", c, rsp_valid, t_rsp[c]); end
      checks++; if (in_flight !== t_inf[c]) begin errors++; $display("FAIL stall_in_flight c%0d: got %0d exp %0d", c, in_flight, t_inf[c]); end
      if (t_rsp[c] != 4'b0000) begin
        checks++;
        if (rsp_read_num !== RW'(t_rd[c]) || rsp_position !== PW'(t_rd[c] + 10) || rsp_data !== sym(RW'(t_rd[c]), PW'(t_rd[c] + 10))) begin
          errors++;
          $display("FAIL stall_rsp_fields c%0d: got rd %0d pos %0d data %h exp %0d %0d %h", c, rsp_read_num, rsp_position, rsp_data, t_rd[c], t_rd[c] + 10, sym(RW'(t_rd[c]), PW'(t_rd[c] + 10)));
        end
      end
      next_cycle();
    end
    stall = 1'b0;
  endtask

  // Pointer at 0; requester 2 parked on the idle status code.
  task automatic test_bubble();
    clear_reqs();
    set_req(2, 1'b1, 2, 50, BUB);
    set_req(3, 1'b1, 3, 51, 5);
    settle();
    checks++; if (req_grant !== 4'b1000 || status_query !== 6'd5) begin errors++; $display("FAIL bubble_grant3: got %b st %0d exp 1000 5", req_grant, status_query); end
    next_cycle();
    set_req(3, 1'b0, 0, 0, 0);
    for (int c = 1; c < 3; c++) begin
      settle();
      checks++; if (req_grant !== 4'b0000 || status_query !== SW'(BUB) || query_read_num !== 6'd0) begin errors++; $display("FAIL bubble_no_grant c%0d: got %b st %b rd %0d exp 0000 %b 0", c, req_grant, status_query, query_read_num, SW'(BUB)); end
      next_cycle();
    end
    clear_reqs();
    settle();
    checks++; if (rsp_valid !== 4'b1000 || rsp_read_num !== 6'd3 || rsp_position !== 7'd51) begin errors++; $display("FAIL bubble_rsp: got %b rd %0d pos %0d exp 1000 3 51", rsp_valid, rsp_read_num, rsp_position); end
    next_cycle();
    settle();
    checks++; if (in_flight !== 2'd0 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL bubble_drain: got inflight %0d rsp %b exp 0 0000", in_flight, rsp_valid); end
    next_cycle();
  endtask

  task automatic test_async_reset();
    clear_reqs();
    set_req(0, 1'b1, 7, 60, 1);
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (req_grant !== 4'b0001) begin errors++; $display("FAIL arst_fill_grant c%0d: got %b exp 0001", c, req_grant); end
      next_cycle();
    end
    #1;
    checks++; if (in_flight !== 2'd3 || rsp_valid !== 4'b0001) begin errors++; $display("FAIL arst_full: got inflight %0d rsp %b exp 3 0001", in_flight, rsp_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 4'b0000 || in_flight !== 2'd0) begin errors++; $display("FAIL arst_immediate: got rsp %b inflight %0d exp 0000 0", rsp_valid, in_flight); end
    checks++; if (status_query !== SW'(BUB) || req_grant !== 4'b0000) begin errors++; $display("FAIL arst_query: got st %b grant %b exp %b 0000", status_query, req_grant, SW'(BUB)); end
    clear_reqs();
    next_cycle();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      checks++; if (rsp_valid !== 4'b0000 || in_flight !== 2'd0) begin errors++; $display("FAIL arst_stale c%0d: got rsp %b inflight %0d exp 0000 0", c, rsp_valid, in_flight); end
      next_cycle();
    end
  endtask

  // Pointer at 0: grant req2 moves it to 3, then lone req1 wins and it becomes 2.
  task automatic test_rr_wrap();
    clear_reqs();
    set_req(2, 1'b1, 12, 70, 2);
    settle();
    checks++; if (req_grant !== 4'b0100) begin errors++; $display("FAIL wrap_grant2: got %b exp 0100", req_grant); end
    next_cycle();
    clear_reqs();
    set_req(1, 1'b1, 11, 71, 3);
    settle();
    checks++; if (req_grant !== 4'b0010) begin errors++; $display("FAIL wrap_grant1: got %b exp 0010", req_grant); end
    next_cycle();
    clear_reqs();
    next_cycle();
    settle();
    checks++; if (rsp_valid !== 4'b0100 || rsp_read_num !== 6'd12 || idle !== 1'b0) begin errors++; $display("FAIL wrap_rsp2: got %b rd %0d idle %b exp 0100 12 0", rsp_valid, rsp_read_num, idle); end
    next_cycle();
    settle();
    checks++; if (rsp_valid !== 4'b0010 || rsp_read_num !== 6'd11 || idle !== 1'b0) begin errors++; $display("FAIL wrap_rsp1: got %b rd %0d idle %b exp 0010 11 0", rsp_valid, rsp_read_num, idle); end
    next_cycle();
    settle();
    checks++; if (idle !== 1'b1 || in_flight !== 2'd0) begin errors++; $display("FAIL wrap_idle: got idle %b inflight %0d exp 1 0", idle, in_flight); end
    next_cycle();
    set_req(1, 1'b1, 11, 72, 3);
    set_req(2, 1'b1, 12, 73, 2);
    settle();
    checks++; if (req_grant !== 4'b0100) begin errors++; $display("FAIL wrap_ptr2: got %b exp 0100", req_grant); end
    next_cycle();
    clear_reqs();
    next_cycle();
    next_cycle();
    settle();
    checks++; if (rsp_valid !== 4'b0100 || rsp_position !== 7'd73) begin errors++; $display("FAIL wrap_ptr2_rsp: got %b pos %0d exp 0100 73", rsp_valid, rsp_position); end
    next_cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    stall   = 1'b0;
    clear_reqs();
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_bubble();
    test_async_reset();
    test_rr_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
